qsfp_ctrl: RTL
==============

QSFP_CTRL -- requirements
Module: qsfp_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, 1563, cycles QSFP0_RESETL is held low (10 us at 156.25 MHz).
REQ-002 Parameter INIT_CYCLES, 312500000, cycles in LPMODE after reset release (2 s module init).
REQ-003 Parameter DEBOUNCE_CYCLES, 15625, cycles a synchronized MODPRSL level must be stable before acceptance.
REQ-004 clk  input  1  single clock domain; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 QSFP0_MODPRSL  input  1  module present, active-low, asynchronous to clk.
REQ-007 QSFP0_INTL  input  1  module interrupt, active-low, asynchronous to clk.
REQ-008 sw_reset  input  1  single-cycle request to restart the module power-up sequence.
REQ-009 int_clr  input  1  single-cycle clear of the sticky interrupt flag.
REQ-010 rate_sel  input  2  rate select value, driven to {FS1,FS0}.
REQ-011 link_up  input  1  Ethernet link status from the MAC/PCS.
REQ-012 QSFP0_RESETL  output  1  module reset, active-low.
REQ-013 QSFP0_LPMODE  output  1  module low-power mode.
REQ-014 QSFP0_MODSELL  output  1  module select, active-low.
REQ-015 QSFP0_FS0 / QSFP0_FS1  output  1 each  registered rate select.
REQ-016 phy_rst  output  1  holds the Ethernet PHY/PCS in reset until READY.
REQ-017 int_pending  output  1  sticky interrupt flag.
REQ-018 state  output  2  current state encoding (ABSENT=0, RESET=1, INIT=2, READY=3).
REQ-019 LED_R / LED_Y / LED_G  output  1 each  status LEDs.

Function
REQ-020 MODPRSL and INTL SHALL each pass through a 2-flop synchronizer before use.
REQ-021 present SHALL update to the synchronized MODPRSL inverse only after it has differed from present for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-022 FSM states SHALL be ABSENT, RESET, INIT, READY, sharing one 32-bit down-counter.
REQ-023 ABSENT: RESETL=0, LPMODE=1, phy_rst=1; present=1 -> RESET with counter loaded to RESET_CYCLES-1.
REQ-024 RESET: RESETL=0, LPMODE=1, phy_rst=1; counter reaching 0 -> INIT with counter loaded to INIT_CYCLES-1; RESETL is low exactly RESET_CYCLES cycles.
REQ-025 INIT: RESETL=1, LPMODE=1, phy_rst=1; counter reaching 0 -> READY.
REQ-026 READY: RESETL=1, LPMODE=0, phy_rst=0; remains until absence or sw_reset.
REQ-027 present=0 in any state SHALL force ABSENT next cycle, overriding sw_reset and counter expiry.
REQ-028 sw_reset in RESET, INIT or READY SHALL enter RESET with counter reloaded; ignored in ABSENT.
REQ-029 {FS1,FS0} SHALL capture rate_sel on every entry to RESET and hold otherwise.
REQ-030 MODSELL SHALL be 0 in all states except ABSENT (1).
REQ-031 int_pending SHALL set when synchronized INTL=0 and state is READY, clear on int_clr; simultaneous set and clear -> set wins.
REQ-032 LED_R = ABSENT or int_pending; LED_Y = RESET or INIT; LED_G = READY and link_up; all registered.

Reset
REQ-033 On rst_n=0: state=ABSENT, RESETL=0, LPMODE=1, MODSELL=1, FS=0, phy_rst=1, int_pending=0, present=0, counters=0, LED_R=1, LED_Y=0, LED_G=0.
REQ-034 Reset asserted mid-sequence SHALL abort immediately; after release the full debounce and power-up sequence repeats.

Structure
REQ-035 State enum and timing defaults SHALL live in the shared package qsfp_pkg.
REQ-036 Debounce SHALL be one sub-module, qsfp_debounce, instantiated for MODPRSL.

Verification (RESET_CYCLES=4, INIT_CYCLES=8, DEBOUNCE_CYCLES=3)
REQ-037 MODPRSL=0 from reset -> state ABSENT->RESET after sync+debounce, RESETL low exactly 4 cycles, LPMODE high 8 more, then READY, phy_rst=0.
REQ-038 MODPRSL glitch high 2 cycles in READY -> no state change; held high 3+ cycles -> ABSENT, MODSELL=1, LED_R=1.
REQ-039 sw_reset in INIT with rate_sel=2'b10 -> RESET, counter reloaded, FS1=1 FS0=0.
REQ-040 sw_reset and module removal debounced in same cycle -> ABSENT.
REQ-041 INTL low in READY -> int_pending=1, LED_R=1; int_clr while INTL still low -> int_pending remains 1.
REQ-042 rst_n pulsed low in INIT -> all outputs at reset values asynchronously; sequence restarts from ABSENT.

Source files
------------

// File: rtl/qsfp_pkg.sv
// Shared definitions for the QSFP module controller: state encoding, timing
// defaults and the per-state pin levels.
package qsfp_pkg;

  localparam int unsigned RESET_CYCLES_DEF    = 32'd1563;
  localparam int unsigned INIT_CYCLES_DEF     = 32'd312500000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd15625;

  typedef enum logic [1:0] {
    ST_ABSENT = 2'd0,
    ST_RESET  = 2'd1,
    ST_INIT   = 2'd2,
    ST_READY  = 2'd3
  } qsfp_state_e;

  typedef struct packed {
    logic resetl;
    logic lpmode;
    logic modsell;
    logic phy_rst;
    logic led_y;
  } qsfp_pins_t;

  // Static pin levels implied by a state; the module is only fully released in READY.
  function automatic qsfp_pins_t pins_for(input qsfp_state_e s);
    qsfp_pins_t p;
    p.resetl  = (s == ST_INIT) || (s == ST_READY);
    p.lpmode  = (s != ST_READY);
    p.modsell = (s == ST_ABSENT);
    p.phy_rst = (s != ST_READY);
    p.led_y   = (s == ST_RESET) || (s == ST_INIT);
    return p;
  endfunction

endpackage

// File: rtl/qsfp_debounce.sv
// Level debouncer: the output follows the input only after the input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module qsfp_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd15625
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic level_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             level_d, level_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Count consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (level_i == level_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      level_d = level_i;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/qsfp_ctrl.sv
// QSFP module power-up controller: presence debounce, reset/low-power
// sequencing, rate select, sticky interrupt and status LEDs.
module qsfp_ctrl
  import qsfp_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = RESET_CYCLES_DEF,
  parameter int unsigned INIT_CYCLES     = INIT_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       QSFP0_MODPRSL,
  input  logic       QSFP0_INTL,
  input  logic       sw_reset,
  input  logic       int_clr,
  input  logic [1:0] rate_sel,
  input  logic       link_up,
  output logic       QSFP0_RESETL,
  output logic       QSFP0_LPMODE,
  output logic       QSFP0_MODSELL,
  output logic       QSFP0_FS0,
  output logic       QSFP0_FS1,
  output logic       phy_rst,
  output logic       int_pending,
  output logic [1:0] state,
  output logic       LED_R,
  output logic       LED_Y,
  output logic       LED_G
);

  localparam logic [31:0] RESET_LOAD = 32'(RESET_CYCLES - 32'd1);
  localparam logic [31:0] INIT_LOAD  = 32'(INIT_CYCLES - 32'd1);

  logic        modprsl_meta_q, modprsl_sync_q;
  logic        intl_meta_q, intl_sync_q;
  logic        present;

  qsfp_state_e state_d, state_q;
  logic [31:0] cnt_d, cnt_q;
  logic [1:0]  fs_d, fs_q;
  qsfp_pins_t  pins_d, pins_q;
  logic        int_pending_d, int_pending_q;
  logic        led_r_d, led_r_q;
  logic        led_g_d, led_g_q;

  // Two-flop synchronizers; idle (deasserted) level is high for both pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modprsl_meta_q <= 1'b1;
      modprsl_sync_q <= 1'b1;
      intl_meta_q    <= 1'b1;
      intl_sync_q    <= 1'b1;
    end else begin
      modprsl_meta_q <= QSFP0_MODPRSL;
      modprsl_sync_q <= modprsl_meta_q;
      intl_meta_q    <= QSFP0_INTL;
      intl_sync_q    <= intl_meta_q;
    end
  end

  qsfp_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_prs_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .level_i(~modprsl_sync_q),
    .level_o(present)
  );

  // Sequencer next state: absence beats everything, then sw_reset, then timers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fs_d    = fs_q;
    if (!present) begin
      state_d = ST_ABSENT;
      cnt_d   = 32'd0;
    end else if (sw_reset && (state_q != ST_ABSENT)) begin
      state_d = ST_RESET;
      cnt_d   = RESET_LOAD;
      fs_d    = rate_sel;
    end else begin
      case (state_q)
        ST_ABSENT: begin
          state_d = ST_RESET;
          cnt_d   = RESET_LOAD;
          fs_d    = rate_sel;
        end
        ST_RESET: begin
          if (cnt_q == 32'd0) begin
            state_d = ST_INIT;
            cnt_d   = INIT_LOAD;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_INIT: begin
          if (cnt_q == 32'd0) begin
            state_d = ST_READY;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_READY: begin
          cnt_d = 32'd0;
        end
        default: begin
          state_d = ST_ABSENT;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  // Output decode from the next state so every output lines up with state.
  always_comb begin
    pins_d = pins_for(state_d);
    if ((intl_sync_q == 1'b0) && (state_q == ST_READY)) begin
      int_pending_d = 1'b1;
    end else if (int_clr) begin
      int_pending_d = 1'b0;
    end else begin
      int_pending_d = int_pending_q;
    end
    led_r_d = (state_d == ST_ABSENT) || int_pending_d;
    led_g_d = (state_d == ST_READY) && link_up;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ABSENT;
      cnt_q         <= 32'd0;
      fs_q          <= 2'b00;
      pins_q        <= pins_for(ST_ABSENT);
      int_pending_q <= 1'b0;
      led_r_q       <= 1'b1;
      led_g_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fs_q          <= fs_d;
      pins_q        <= pins_d;
      int_pending_q <= int_pending_d;
      led_r_q       <= led_r_d;
      led_g_q       <= led_g_d;
    end
  end

  assign QSFP0_RESETL  = pins_q.resetl;
  assign QSFP0_LPMODE  = pins_q.lpmode;
  assign QSFP0_MODSELL = pins_q.modsell;
  assign phy_rst       = pins_q.phy_rst;
  assign LED_Y         = pins_q.led_y;
  assign QSFP0_FS0     = fs_q[0];
  assign QSFP0_FS1     = fs_q[1];
  assign int_pending   = int_pending_q;
  assign state         = state_q;
  assign LED_R         = led_r_q;
  assign LED_G         = led_g_q;

endmodule
